// File: rtl/ariane_soc_pkg.sv
// Shared SoC-level definitions: peripheral count plus the types used by the
// MOP instruction collector (state enum and 64-bit policy word).
package ariane_soc;

  localparam int NB_PERIPHERALS     = 8;
  localparam int MOP_BYTES_PER_WORD = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } mop_coll_state_e;

  typedef logic [63:0] mop_word_t;

endpackage

// File: rtl/mop_word_fifo.sv
// Small synchronous FIFO holding assembled policy words.
// Pointers carry one extra wrap bit so full and empty are told apart by
// comparing the MSBs. A push into a full FIFO is accepted only when a pop
// frees the head entry on the same edge. flush_i empties the FIFO.
module mop_word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem[rd_q[AW-1:0]];

  // Pointer update; flush has priority over any push/pop that cycle
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage write; contents are data only and need no reset
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mop_instr_collector.sv
// Per-peripheral receive stage behind the MOP loader. Bytes strobed on this
// instance's load_ctrl bit are packed little-endian into a NUM_BYTES word,
// which is pushed into a small FIFO and offered over valid/ready.
// Optional build macro MOP_PARITY_CHK_EN: the last byte of each word must
// equal the XOR of the preceding bytes, otherwise the word is dropped and
// parity_err_o pulses.
module mop_instr_collector
  import ariane_soc::*;
#(
  parameter int PERIPH_IDX = 0,
  parameter int NUM_BYTES  = MOP_BYTES_PER_WORD,
  parameter int DEPTH      = 2,
  parameter int TIMEOUT    = 64,
  localparam int WORD_W    = 8 * NUM_BYTES,
  localparam int CNT_W     = $clog2(NUM_BYTES + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic [NB_PERIPHERALS-1:0] load_ctrl_i,
  input  logic [7:0]                instrut_value_i,
  output logic [WORD_W-1:0]         word_o,
  output logic                      word_valid_o,
  input  logic                      word_ready_i,
  output logic                      busy_o,
  output logic [CNT_W-1:0]          byte_cnt_o,
  output logic                      timeout_o,
  output logic                      overflow_o,
  output logic                      parity_err_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  mop_coll_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [WORD_W-1:0] asm_q, word_c;
  logic strobe, last_byte, commit, tmo_fire, par_ok;
  logic push, pop, fifo_full, fifo_empty;
  logic timeout_q, overflow_q;
  logic [WORD_W-1:0] fifo_rdata;
  logic unused_load_ctrl;

`ifdef MOP_PARITY_CHK_EN
  logic par_err_q;

  // Last byte must equal the XOR of all earlier bytes of the word
  function automatic logic parity_ok(input logic [WORD_W-1:0] w);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < NUM_BYTES - 1; k++) acc = acc ^ w[8*k +: 8];
    return acc == w[8*(NUM_BYTES-1) +: 8];
  endfunction

  assign par_ok = parity_ok(word_c);
`else
  assign par_ok = 1'b1;
`endif

  assign strobe           = load_ctrl_i[PERIPH_IDX];
  assign unused_load_ctrl = ^load_ctrl_i;
  assign last_byte        = strobe && (cnt_q == CNT_W'(NUM_BYTES - 1));
  assign pop              = word_valid_o && word_ready_i;
  assign push             = commit && par_ok;

  // Merge the incoming byte into the partial word at the current byte slot
  always_comb begin
    word_c = asm_q;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (cnt_q == CNT_W'(k)) word_c[8*k +: 8] = instrut_value_i;
    end
  end

  // Collector next-state: byte counting, commit and idle timeout
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    commit   = 1'b0;
    tmo_fire = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (strobe) begin
            tmo_d = '0;
            if (last_byte) begin
              commit = 1'b1;
            end else begin
              state_d = COLLECT;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        COLLECT: begin
          if (strobe) begin
            tmo_d = '0;
            if (last_byte) begin
              commit  = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            tmo_fire = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
            tmo_d    = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      endcase
    end
  end

  // Control state, status pulses and sticky overflow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tmo_q      <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      timeout_q <= tmo_fire;
      if (clear_i)                            overflow_q <= 1'b0;
      else if (push && fifo_full && !pop)     overflow_q <= 1'b1;
    end
  end

`ifdef MOP_PARITY_CHK_EN
  // Parity drop pulse, issued for the edge that would have committed
  always_ff @(posedge clk_i) begin
    if (rst_i) par_err_q <= 1'b0;
    else       par_err_q <= commit && !par_ok;
  end

  assign parity_err_o = par_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  // Partial-word assembly register (data path, not reset)
  always_ff @(posedge clk_i) begin
    if (strobe && !clear_i) asm_q <= word_c;
  end

  mop_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (clear_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (word_c),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign word_valid_o = !fifo_empty;
  assign word_o       = fifo_empty ? '0 : fifo_rdata;
  assign busy_o       = (state_q == COLLECT);
  assign byte_cnt_o   = cnt_q;
  assign timeout_o    = timeout_q;
  assign overflow_o   = overflow_q;

endmodule
